rx_to_mem: RTL



---
 rtl/rx_to_mem.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/rx_to_mem.sv
// Frames a UART byte stream (START_BYTE, N bytes of A, N bytes of B) into row-major
// matrix memory writes. Define RX_CHECKSUM_EN to require a trailing mod-256 sum byte.
module rx_to_mem #(
  parameter int          ROW            = 2,
  parameter int          COLUMN         = 2,
  parameter int          ADDR_W         = 6,
  parameter logic [7:0]  START_BYTE     = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic              busy,
  output logic              write_A,
  output logic              write_B,
  output logic [ADDR_W-1:0] write_address,
  output logic [7:0]        write_value,
  output logic              load_done,
  output logic              load_err
);

  localparam int N     = ROW * COLUMN;
  localparam int CNT_W = $clog2(N) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    DONE
`ifdef RX_CHECKSUM_EN
    , CHECK
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                write_a_q, write_a_d;
  logic                write_b_q, write_b_d;
  logic [ADDR_W-1:0]   write_address_q, write_address_d;
  logic [7:0]          write_value_q, write_value_d;
  logic                load_done_q, load_done_d;
  logic                load_err_q, load_err_d;
`ifdef RX_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    tmo_d           = tmo_q;
    write_a_d       = 1'b0;
    write_b_d       = 1'b0;
    write_address_d = write_address_q;
    write_value_d   = write_value_q;
    load_done_d     = 1'b0;
    load_err_d      = load_err_q;
`ifdef RX_CHECKSUM_EN
    sum_d           = sum_q;
`endif
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (rx_valid && rx_byte == START_BYTE) begin
          state_d    = LOAD_A;
          cnt_d      = '0;
          load_err_d = 1'b0;
`ifdef RX_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end
      LOAD_A, LOAD_B: begin
        // A byte arriving on the expiry cycle is still accepted.
        if (rx_valid) begin
          tmo_d           = '0;
          write_a_d       = (state_q == LOAD_A);
          write_b_d       = (state_q == LOAD_B);
          write_address_d = ADDR_W'(cnt_q);
          write_value_d   = rx_byte;
`ifdef RX_CHECKSUM_EN
          sum_d           = sum_q + rx_byte;
`endif
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (state_q == LOAD_A) begin
              state_d = LOAD_B;
            end else begin
`ifdef RX_CHECKSUM_EN
              state_d = CHECK;
`else
              state_d = DONE;
`endif
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          load_err_d = 1'b1;
          state_d    = IDLE;
          tmo_d      = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
`ifdef RX_CHECKSUM_EN
      CHECK: begin
        if (rx_valid) begin
          tmo_d = '0;
          if (rx_byte == sum_q) begin
            state_d = DONE;
          end else begin
            load_err_d = 1'b1;
            state_d    = IDLE;
          end
        end else if (tmo_q == TMO_LAST) begin
          load_err_d = 1'b1;
          state_d    = IDLE;
          tmo_d      = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
`endif
      DONE: begin
        // Any byte seen here is dropped; the frame is already complete.
        load_done_d = 1'b1;
        tmo_d       = '0;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      tmo_q           <= '0;
      write_a_q       <= 1'b0;
      write_b_q       <= 1'b0;
      write_address_q <= '0;
      write_value_q   <= '0;
      load_done_q     <= 1'b0;
      load_err_q      <= 1'b0;
`ifdef RX_CHECKSUM_EN
      sum_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      tmo_q           <= tmo_d;
      write_a_q       <= write_a_d;
      write_b_q       <= write_b_d;
      write_address_q <= write_address_d;
      write_value_q   <= write_value_d;
      load_done_q     <= load_done_d;
      load_err_q      <= load_err_d;
`ifdef RX_CHECKSUM_EN
      sum_q           <= sum_d;
`endif
    end
  end

  assign busy          = (state_q != IDLE);
  assign write_A       = write_a_q;
  assign write_B       = write_b_q;
  assign write_address = write_address_q;
  assign write_value   = write_value_q;
  assign load_done     = load_done_q;
  assign load_err      = load_err_q;

endmodule
